// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu issue stage: alu control codes, aluop
// encodings and the issue FSM state encoding.
package alu_issue_pkg;

  // Control codes driven to the external alu
  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;

  // aluop field encodings coming from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // R-type funct3 values that this stage supports
  localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
  localparam logic [2:0] FUNCT3_OR     = 3'b110;
  localparam logic [2:0] FUNCT3_AND    = 3'b111;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } issue_state_e;

endpackage : alu_issue_pkg

// File: rtl/alu_ctrl_decode.sv
// Combinational alu control decode: maps aluop/funct3/funct7b5 to a control
// code and flags every combination outside the supported table as illegal.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] control,
  output logic       illegal
);

  // Decode table; unsupported R-type encodings and the reserved aluop are illegal
  always_comb begin
    control = 4'b0000;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: control = ALU_CTRL_ADD;
      ALUOP_SUB: control = ALU_CTRL_SUB;
      ALUOP_RTYPE: begin
        case ({funct3, funct7b5})
          {FUNCT3_ADDSUB, 1'b0}: control = ALU_CTRL_ADD;
          {FUNCT3_ADDSUB, 1'b1}: control = ALU_CTRL_SUB;
          {FUNCT3_AND,    1'b0}: control = ALU_CTRL_AND;
          {FUNCT3_OR,     1'b0}: control = ALU_CTRL_OR;
          default: begin
            control = 4'b0000;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        control = 4'b0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : alu_ctrl_decode

// File: rtl/alu_issue.sv
// Alu issue stage: accepts one request at a time, drives registered operands
// and control code to an external combinational alu, captures its result and
// holds the response until the consumer takes it.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
);

  logic [3:0]       w_ctrl;
  logic             w_illegal;

  issue_state_e     r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_alu_data1;
  logic [WIDTH-1:0] r_alu_data2;
  logic [3:0]       r_alu_control;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_err;

  alu_ctrl_decode u_decode (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .control  (w_ctrl),
    .illegal  (w_illegal)
  );

  // Issue FSM with all outputs registered; an illegal request skips EXEC and
  // leaves the alu-facing registers untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_alu_data1   <= '0;
      r_alu_data2   <= '0;
      r_alu_control <= 4'b0000;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_illegal) begin
              r_out_result <= '0;
              r_out_zero   <= 1'b0;
              r_out_err    <= 1'b1;
              r_out_valid  <= 1'b1;
              r_state      <= ST_HOLD;
            end else begin
              r_alu_data1   <= in_a;
              r_alu_data2   <= in_b;
              r_alu_control <= w_ctrl;
              r_state       <= ST_EXEC;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_out_result <= alu_result;
          r_out_zero   <= alu_zero;
          r_out_err    <= 1'b0;
          r_out_valid  <= 1'b1;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          // The consume edge returns to IDLE but never accepts a new request
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign alu_data1   = r_alu_data1;
  assign alu_data2   = r_alu_data2;
  assign alu_control = r_alu_control;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_err     = r_out_err;

endmodule : alu_issue

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a directed vector table, randomized
// requests against a behavioural model, and hand-written reset sequences.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   f3;
    logic         f7;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   exp_code;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_err;
    int           hold;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_aluop;
  logic [2:0]   in_funct3;
  logic         in_funct7b5;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] alu_data1;
  logic [W-1:0] alu_data2;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]   last_ctrl;
  logic [W-1:0] last_a;
  logic [W-1:0] last_b;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_err     (out_err)
  );

  // External combinational alu the block drives
  always_comb begin
    case (alu_control)
      ALU_CTRL_ADD: alu_result = alu_data1 + alu_data2;
      ALU_CTRL_SUB: alu_result = alu_data1 - alu_data2;
      ALU_CTRL_AND: alu_result = alu_data1 & alu_data2;
      ALU_CTRL_OR:  alu_result = alu_data1 | alu_data2;
      default:      alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: what the instruction means, not how it is decoded
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic legal, output logic [3:0] code,
                                output logic [W-1:0] res);
    legal = 1'b1;
    code  = 4'b0000;
    res   = '0;
    if (op == 2'd0) begin
      code = ALU_CTRL_ADD; res = a + b;
    end else if (op == 2'd1) begin
      code = ALU_CTRL_SUB; res = a - b;
    end else if (op == 2'd2 && f3 == 3'd0 && !f7) begin
      code = ALU_CTRL_ADD; res = a + b;
    end else if (op == 2'd2 && f3 == 3'd0 && f7) begin
      code = ALU_CTRL_SUB; res = a - b;
    end else if (op == 2'd2 && f3 == 3'd7 && !f7) begin
      code = ALU_CTRL_AND; res = a & b;
    end else if (op == 2'd2 && f3 == 3'd6 && !f7) begin
      code = ALU_CTRL_OR; res = a | b;
    end else begin
      legal = 1'b0;
    end
  endfunction

  task automatic scramble();
    in_aluop    = 2'($urandom_range(0, 3));
    in_funct3   = 3'($urandom_range(0, 7));
    in_funct7b5 = 1'($urandom_range(0, 1));
    in_a        = {$urandom, $urandom};
    in_b        = {$urandom, $urandom};
  endtask

  task automatic run_req(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, " in_ready idle"}, W'(in_ready), W'(1));
    in_aluop = v.op; in_funct3 = v.f3; in_funct7b5 = v.f7; in_a = v.a; in_b = v.b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    if (!v.exp_err) begin
      chk({nm, " valid early"}, W'(out_valid), W'(0));
      chk({nm, " in_ready exec"}, W'(in_ready), W'(0));
      chk({nm, " alu_control"}, W'(alu_control), W'(v.exp_code));
      chk({nm, " alu_data1"}, alu_data1, v.a);
      chk({nm, " alu_data2"}, alu_data2, v.b);
      last_ctrl = v.exp_code; last_a = v.a; last_b = v.b;
      @(negedge clk);
    end else begin
      chk({nm, " ctrl kept"}, W'(alu_control), W'(last_ctrl));
      chk({nm, " data1 kept"}, alu_data1, last_a);
    end
    chk({nm, " out_valid"}, W'(out_valid), W'(1));
    chk({nm, " out_result"}, out_result, v.exp_res);
    chk({nm, " out_zero"}, W'(out_zero), W'(v.exp_zero));
    chk({nm, " out_err"}, W'(out_err), W'(v.exp_err));
    for (int i = 0; i < v.hold; i++) begin
      scramble();
      in_valid = 1'b1;
      @(negedge clk);
      chk({nm, " hold valid"}, W'(out_valid), W'(1));
      chk({nm, " hold result"}, out_result, v.exp_res);
      chk({nm, " hold err"}, W'(out_err), W'(v.exp_err));
      chk({nm, " hold in_ready"}, W'(in_ready), W'(0));
      chk({nm, " hold ctrl"}, W'(alu_control), W'(last_ctrl));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk({nm, " consumed"}, W'(out_valid), W'(0));
    chk({nm, " ready again"}, W'(in_ready), W'(1));
    chk({nm, " no 2nd accept"}, alu_data1, last_a);
  endtask

  vec_t tbl[10];
  vec_t rv;
  logic         m_legal;
  logic [3:0]   m_code;
  logic [W-1:0] m_res;

  initial begin
    // op, f3, f7, a, b, code, result, zero, err, hold
    tbl[0] = '{2'b00, 3'd0, 1'b0, 64'd3, 64'd2, ALU_CTRL_ADD, 64'd5, 1'b0, 1'b0, 1};
    tbl[1] = '{2'b01, 3'd0, 1'b0, 64'd3, 64'd3, ALU_CTRL_SUB, 64'd0, 1'b1, 1'b0, 0};
    tbl[2] = '{2'b10, 3'd7, 1'b0, 64'd3, 64'd2, ALU_CTRL_AND, 64'd2, 1'b0, 1'b0, 0};
    tbl[3] = '{2'b10, 3'd6, 1'b0, 64'd3, 64'd2, ALU_CTRL_OR,  64'd3, 1'b0, 1'b0, 4};
    tbl[4] = '{2'b10, 3'd0, 1'b1, 64'd10, 64'd4, ALU_CTRL_SUB, 64'd6, 1'b0, 1'b0, 0};
    tbl[5] = '{2'b10, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_CTRL_ADD, 64'd0, 1'b1, 1'b0, 0};
    tbl[6] = '{2'b11, 3'd0, 1'b0, 64'd9, 64'd9, 4'b0000, 64'd0, 1'b0, 1'b1, 2};
    tbl[7] = '{2'b10, 3'd1, 1'b0, 64'd9, 64'd1, 4'b0000, 64'd0, 1'b0, 1'b1, 0};
    tbl[8] = '{2'b10, 3'd7, 1'b1, 64'd9, 64'd1, 4'b0000, 64'd0, 1'b0, 1'b1, 0};
    tbl[9] = '{2'b01, 3'd0, 1'b0, 64'd0, 64'd1, ALU_CTRL_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_aluop = 2'b00; in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_a = '0; in_b = '0;
    last_ctrl = 4'b0000; last_a = '0; last_b = '0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst out_result", out_result, '0);
    chk("rst out_err", W'(out_err), W'(0));
    chk("rst alu_data1", alu_data1, '0);
    chk("rst alu_control", W'(alu_control), W'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 10; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Reset while in EXEC drops the request
    @(negedge clk);
    in_aluop = ALUOP_ADD; in_a = 64'd7; in_b = 64'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid-exec ctrl", W'(alu_control), W'(ALU_CTRL_ADD));
    reset = 1'b1;
    #1;
    chk("rst exec valid", W'(out_valid), W'(0));
    chk("rst exec ctrl", W'(alu_control), W'(0));
    chk("rst exec data2", alu_data2, '0);
    @(negedge clk);
    reset = 1'b0;
    last_ctrl = 4'b0000; last_a = '0; last_b = '0;
    @(negedge clk);
    chk("post-rst valid", W'(out_valid), W'(0));
    chk("post-rst in_ready", W'(in_ready), W'(1));
    run_req(tbl[0], "add after reset");

    // Reset while holding an error response
    @(negedge clk);
    in_aluop = ALUOP_RSVD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold err before rst", W'(out_err), W'(1));
    reset = 1'b1;
    #1;
    chk("rst hold valid", W'(out_valid), W'(0));
    chk("rst hold err", W'(out_err), W'(0));
    @(negedge clk);
    reset = 1'b0;
    last_ctrl = 4'b0000; last_a = '0; last_b = '0;

    // Randomized requests against the behavioural model
    for (int n = 0; n < 40; n++) begin
      rv.op = 2'($urandom_range(0, 3));
      rv.f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 7));
      rv.f7 = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      rv.a  = {$urandom, $urandom};
      rv.b  = ($urandom_range(0, 4) == 0) ? rv.a : {$urandom, $urandom};
      rv.hold = $urandom_range(0, 3);
      model(rv.op, rv.f3, rv.f7, rv.a, rv.b, m_legal, m_code, m_res);
      rv.exp_code = m_code;
      rv.exp_res  = m_legal ? m_res : '0;
      rv.exp_zero = m_legal && (m_res == '0);
      rv.exp_err  = !m_legal;
      run_req(rv, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_issue
